// File: rtl/scope_frame_reader.sv
// Captures one triggered burst of 8-bit scope samples (optionally decimated) into a
// frame buffer, freezes it, and serves it to the display through a 1-cycle read port.
module scope_frame_reader #(
  parameter int DEPTH  = 320,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        sampleIn,
  input  logic              sampleValid,
  input  logic [3:0]        decim,
  input  logic              rearm,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [7:0]        rdData,
  output logic              rdValid,
  output logic              frameReady,
  output logic [ADDR_W:0]   frameLen,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

  localparam logic [ADDR_W:0] C_LAST = (ADDR_W+1)'(DEPTH-1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W:0]   r_wrPtr;
  logic [3:0]        r_decCount;
  logic [ADDR_W:0]   r_frameLen;
  logic [7:0]        r_mem [0:DEPTH-1];
  logic [7:0]        r_ramQ;
  logic              r_rdHit;
  logic              r_rdValid;
  logic              w_write;
  logic              w_decHit;
  logic              w_lastSlot;
  logic              w_rdHit;
  logic [ADDR_W-1:0] w_wrAddr;
  logic [ADDR_W-1:0] w_rdIdx;

  assign w_decHit   = (r_decCount == decim);
  assign w_lastSlot = (r_wrPtr == C_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (sampleValid) w_stateNext = (DEPTH == 1) ? S_FULL : S_FILL;
      S_FILL: begin
        // rearm wins over a coincident sample; a burst ending early freezes a partial frame
        if (rearm)                       w_stateNext = S_IDLE;
        else if (!sampleValid)           w_stateNext = S_FULL;
        else if (w_decHit && w_lastSlot) w_stateNext = S_FULL;
      end
      S_FULL: if (rearm) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state == S_FILL);
    frameReady = (r_state == S_FULL);
    w_write    = ((r_state == S_IDLE) && sampleValid) ||
                 ((r_state == S_FILL) && !rearm && sampleValid && w_decHit);
    w_wrAddr   = (r_state == S_IDLE) ? '0 : r_wrPtr[ADDR_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_decCount <= '0;
      r_frameLen <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (sampleValid) begin
          r_wrPtr    <= (ADDR_W+1)'(1);
          r_decCount <= '0;
          r_frameLen <= (ADDR_W+1)'(1);
        end
        S_FILL: begin
          if (rearm) begin
            r_wrPtr <= '0;
          end else if (sampleValid) begin
            if (w_decHit) begin
              r_wrPtr    <= r_wrPtr + 1'b1;
              r_decCount <= '0;
              r_frameLen <= r_wrPtr + 1'b1;
            end else begin
              r_decCount <= r_decCount + 1'b1;
            end
          end
        end
        S_FULL: if (rearm) r_wrPtr <= '0;
        default: r_wrPtr <= '0;
      endcase
    end
  end

  // Only frozen, in-range slots are returned; everything else reads as zero.
  assign w_rdHit = (r_state == S_FULL) && ({1'b0, rdAddr} < r_frameLen);
  assign w_rdIdx = w_rdHit ? rdAddr : '0;

  always_ff @(posedge clk) begin
    if (w_write) r_mem[w_wrAddr] <= sampleIn;
    if (rdReq)   r_ramQ <= r_mem[w_rdIdx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdValid <= 1'b0;
      r_rdHit   <= 1'b0;
    end else begin
      r_rdValid <= rdReq;
      if (rdReq) r_rdHit <= w_rdHit;
    end
  end

  assign rdData   = r_rdHit ? r_ramQ : 8'h00;
  assign rdValid  = r_rdValid;
  assign frameLen = r_frameLen;

endmodule

// File: tb/tb_scope_frame_reader.sv
// Directed bench for scope_frame_reader: capture, decimation, partial frames, read port,
// rearm/abort handling and asynchronous reset.
module tb_scope_frame_reader;

  localparam int DEPTH  = 320;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        sampleIn;
  logic              sampleValid;
  logic [3:0]        decim;
  logic              rearm;
  logic              rdReq;
  logic [ADDR_W-1:0] rdAddr;
  logic [7:0]        rdData;
  logic              rdValid;
  logic              frameReady;
  logic [ADDR_W:0]   frameLen;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scope_frame_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .sampleIn(sampleIn), .sampleValid(sampleValid),
    .decim(decim), .rearm(rearm), .rdReq(rdReq), .rdAddr(rdAddr),
    .rdData(rdData), .rdValid(rdValid), .frameReady(frameReady),
    .frameLen(frameLen), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int addr, input int exp, input string tag);
    rdAddr = addr[ADDR_W-1:0];
    rdReq  = 1'b1;
    tick();
    rdReq  = 1'b0;
    check({tag, "_valid"}, 32'(rdValid), 32'd1);
    check(tag, 32'(rdData), exp[31:0]);
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  task automatic burst(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(base + i);
      tick();
    end
    sampleValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sampleIn = '0; sampleValid = 1'b0; decim = '0;
    rearm = 1'b0; rdReq = 1'b0; rdAddr = '0;
    tick(); tick();
    check("rst_frameReady", 32'(frameReady), 0);
    check("rst_busy",       32'(busy), 0);
    check("rst_frameLen",   32'(frameLen), 0);
    check("rst_rdValid",    32'(rdValid), 0);
    check("rst_rdData",     32'(rdData), 0);
    reset = 1'b0;
    tick();

    // Full capture, no decimation, 400-cycle burst
    for (int i = 0; i < 400; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(i);
      tick();
      if (i == 0)   check("full_busy_start", 32'(busy), 1);
      if (i == 318) check("full_ready_318",  32'(frameReady), 0);
      if (i == 319) begin
        check("full_ready_319", 32'(frameReady), 1);
        check("full_busy_319",  32'(busy), 0);
      end
    end
    sampleValid = 1'b0;
    tick();
    check("full_len", 32'(frameLen), 320);
    rd(5,   5,  "full_rd5");
    rd(319, 63, "full_rd319");
    rd(0,   0,  "full_rd0_no_wrap");
    pulse_rearm();
    check("rearm_ready", 32'(frameReady), 0);
    check("rearm_len_hold", 32'(frameLen), 320);

    // Decimation by 4
    decim = 4'd3;
    for (int i = 0; i < 1300; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(i);
      tick();
      if (i == 1275) begin
        check("dec_len_1276",   32'(frameLen), 319);
        check("dec_ready_1276", 32'(frameReady), 0);
      end
      if (i == 1276) begin
        check("dec_len_1277",   32'(frameLen), 320);
        check("dec_ready_1277", 32'(frameReady), 1);
      end
    end
    sampleValid = 1'b0;
    decim = 4'd0;
    tick();
    rd(10,  40,  "dec_rd10");
    rd(100, 144, "dec_rd100");
    pulse_rearm();

    // Short burst of 50, with a read issued mid-FILL
    for (int i = 0; i < 50; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(100 + i);
      if (i == 10) begin rdReq = 1'b1; rdAddr = '0; end
      tick();
      rdReq = 1'b0;
      if (i == 10) begin
        check("fill_rd_valid", 32'(rdValid), 1);
        check("fill_rd_zero",  32'(rdData), 0);
      end
    end
    sampleValid = 1'b0;
    tick();
    check("short_len",   32'(frameLen), 50);
    check("short_ready", 32'(frameReady), 1);
    rd(49,  149, "short_rd49");
    rd(50,  0,   "short_rd50");
    rd(400, 0,   "short_rd400");

    // Back-to-back reads
    for (int k = 0; k < 4; k++) begin
      rdAddr = 9'(k);
      rdReq  = 1'b1;
      tick();
      check($sformatf("b2b_valid%0d", k), 32'(rdValid), 1);
      check($sformatf("b2b_data%0d", k),  32'(rdData), 32'(100 + k));
    end
    rdReq = 1'b0;
    tick();
    check("b2b_valid_end", 32'(rdValid), 0);
    check("b2b_data_hold", 32'(rdData), 103);

    // Burst while FULL is ignored
    burst(20, 8'hEE);
    check("full_ignore_ready", 32'(frameReady), 1);
    check("full_ignore_len",   32'(frameLen), 50);
    rd(0,  100, "full_ignore_rd0");
    rd(20, 120, "full_ignore_rd20");

    // rdReq coincident with rearm
    rearm = 1'b1; rdReq = 1'b1; rdAddr = 9'd7;
    tick();
    rearm = 1'b0; rdReq = 1'b0;
    check("coinc_valid", 32'(rdValid), 1);
    check("coinc_data",  32'(rdData), 107);
    check("coinc_ready", 32'(frameReady), 0);
    check("coinc_len",   32'(frameLen), 50);
    rd(7, 0, "idle_rd7");

    // Abort mid-FILL at wrPtr = 100, rearm beating a coincident sample
    for (int i = 0; i < 100; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(200 + i);
      tick();
    end
    check("abort_pre_len",  32'(frameLen), 100);
    check("abort_pre_busy", 32'(busy), 1);
    rearm = 1'b1; sampleValid = 1'b1; sampleIn = 8'h55;
    tick();
    rearm = 1'b0; sampleValid = 1'b0;
    check("abort_busy",  32'(busy), 0);
    check("abort_ready", 32'(frameReady), 0);
    check("abort_len",   32'(frameLen), 100);
    tick();
    burst(5, 50);
    tick();
    check("post_abort_len", 32'(frameLen), 5);
    rd(0, 50, "post_abort_rd0");
    rd(4, 54, "post_abort_rd4");
    rd(5, 0,  "post_abort_rd5");
    pulse_rearm();

    // Asynchronous reset mid-FILL
    for (int i = 0; i < 30; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(10 + i);
      if (i == 29) begin rdReq = 1'b1; rdAddr = 9'd3; end
      tick();
    end
    rdReq = 1'b0;
    check("ares_pre_busy",    32'(busy), 1);
    check("ares_pre_rdValid", 32'(rdValid), 1);
    #2;
    reset = 1'b1; sampleValid = 1'b0;
    #1;
    check("ares_ready",   32'(frameReady), 0);
    check("ares_busy",    32'(busy), 0);
    check("ares_rdValid", 32'(rdValid), 0);
    check("ares_len",     32'(frameLen), 0);
    #2;
    reset = 1'b0;
    tick();
    burst(8, 60);
    tick();
    check("ares_new_len",   32'(frameLen), 8);
    check("ares_new_ready", 32'(frameReady), 1);
    rd(7, 67, "ares_new_rd7");
    rd(0, 60, "ares_new_rd0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
